// File: rtl/nano_pkg.sv
// Shared types and width constants for the nano CPU core.
package nano_pkg;

    localparam int unsigned DataW   = 16;
    localparam int unsigned AddrW   = 8;
    localparam int unsigned NumRegs = 16;

    typedef enum logic [3:0] {
        OpRead   = 4'h0,
        OpWrite  = 4'h1,
        OpJmp    = 4'h2,
        OpBranch = 4'h3,
        OpXor    = 4'h4,
        OpAnd    = 4'h5,
        OpAdd    = 4'h6,
        OpLess   = 4'h7,
        OpInc    = 4'h8,
        OpDec    = 4'h9,
        OpEnd    = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        StFetch,
        StExec,
        StHalt
    } state_e;

endpackage

// File: rtl/nano_cpu_if.sv
// Word-memory bus between the nano CPU (master) and its 256x16 memory (slave).
interface nano_cpu_if;
    import nano_pkg::*;

    logic [AddrW-1:0] address;
    logic [DataW-1:0] dataR;
    logic [DataW-1:0] dataW;
    logic             ce;
    logic             we;

    modport master (
        output address,
        output dataW,
        output ce,
        output we,
        input  dataR
    );

    modport slave (
        input  address,
        input  dataW,
        input  ce,
        input  we,
        output dataR
    );

endinterface

// File: rtl/nano_alu.sv
// Combinational ALU for the nano CPU register-to-register instructions.
module nano_alu
    import nano_pkg::*;
(
    input  opcode_e          op_i,
    input  logic [DataW-1:0] a_i,
    input  logic [DataW-1:0] b_i,
    output logic [DataW-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            OpXor:   result_o = a_i ^ b_i;
            OpAnd:   result_o = a_i & b_i;
            OpAdd:   result_o = a_i + b_i;
            OpLess:  result_o = {{(DataW-1){1'b0}}, (a_i < b_i)};
            OpInc:   result_o = a_i + DataW'(1);
            OpDec:   result_o = a_i - DataW'(1);
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/nano_cpu.sv
// Two-cycle (fetch/execute) 16-bit CPU with a 16-entry register file on a word bus.
module nano_cpu
    import nano_pkg::*;
(
    input  logic       ck,
    input  logic       rst,
    nano_cpu_if.master bus
);

    state_e           state_q, state_d;
    logic [AddrW-1:0] pc_q, pc_d;
    logic [DataW-1:0] ir_q, ir_d;
    logic [DataW-1:0] regs_q [NumRegs];
    logic [DataW-1:0] regs_d [NumRegs];

    opcode_e          op;
    logic [3:0]       rt, rs1, rs2, r;
    logic [AddrW-1:0] maddr;
    logic [DataW-1:0] alu_res;

    assign op    = opcode_e'(ir_q[15:12]);
    assign rt    = ir_q[11:8];
    assign rs1   = ir_q[7:4];
    assign rs2   = ir_q[3:0];
    assign maddr = ir_q[11:4];
    assign r     = ir_q[3:0];

    nano_alu u_alu (
        .op_i     (op),
        .a_i      (regs_q[rs1]),
        .b_i      (regs_q[rs2]),
        .result_o (alu_res)
    );

    always_ff @(posedge ck) begin
        if (!rst) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: state_d = StExec;
            StExec:  state_d = (op == OpEnd) ? StHalt : StFetch;
            default: state_d = StHalt;
        endcase
    end

    always_comb begin
        pc_d   = pc_q;
        ir_d   = ir_q;
        regs_d = regs_q;
        if (state_q == StFetch) begin
            ir_d = bus.dataR;
            pc_d = pc_q + AddrW'(1);
        end else if (state_q == StExec) begin
            case (op)
                OpRead:   regs_d[r] = bus.dataR;
                OpJmp:    pc_d = maddr;
                OpBranch: if (regs_q[r] != '0) pc_d = maddr;
                OpXor, OpAnd, OpAdd, OpLess, OpInc, OpDec: regs_d[rt] = alu_res;
                default: ;
            endcase
        end
    end

    // Bus is forced idle while reset is held so an aborted WRITE never strobes.
    always_comb begin
        bus.address = pc_q;
        bus.ce      = 1'b0;
        bus.we      = 1'b0;
        bus.dataW   = '0;
        if (!rst) begin
            bus.address = '0;
        end else begin
            case (state_q)
                StFetch: bus.ce = 1'b1;
                StExec: begin
                    if (op == OpRead) begin
                        bus.address = maddr;
                        bus.ce      = 1'b1;
                    end else if (op == OpWrite) begin
                        bus.address = maddr;
                        bus.ce      = 1'b1;
                        bus.we      = 1'b1;
                        bus.dataW   = regs_q[r];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nano_cpu.sv
// Self-checking bench for nano_cpu: ALU vector table plus program-level sequences.
module tb_nano_cpu;
    import nano_pkg::*;

    logic ck = 1'b0;
    logic rst = 1'b0;
    always #5 ck = ~ck;

    nano_cpu_if bus ();

    nano_cpu dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] mem [256];
    assign bus.dataR = mem[bus.address];
    always @(posedge ck) if (bus.we) mem[bus.address] <= bus.dataW;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] want;
    } alu_vec_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_vec = 0;
    int  n_bad = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, want);
        end
    endtask

    // Every DUT memory write is matched against the next queued expectation.
    always @(negedge ck) begin
        if (rst && bus.we) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected write: got addr %h data %h, required no write",
                         bus.address, bus.dataW);
            end else begin
                mon_e = exp_q.pop_front();
                check("write addr", 16'(bus.address), 16'(mon_e.addr));
                check("write data", bus.dataW, mon_e.data);
            end
        end
        if (!bus.we) check("dataW idle", bus.dataW, 16'h0000);
    end

    task automatic fill_mem(input logic [15:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge ck);
        check("reset address", 16'(bus.address), 16'h0000);
        check("reset ce", 16'(bus.ce), 16'h0000);
        check("reset we", 16'(bus.we), 16'h0000);
    endtask

    task automatic release_reset();
        rst = 1'b1;
        #1;
        check("first fetch address", 16'(bus.address), 16'h0000);
        check("first fetch ce", 16'(bus.ce), 16'h0001);
    endtask

    task automatic run_until_drained(input int budget, input string name);
        int i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(negedge ck);
            i++;
        end
        check(name, 16'(exp_q.size()), 16'h0000);
    endtask

    task automatic check_halted(input logic [7:0] pc, input string name);
        repeat (6) @(negedge ck);
        check({name, " ce"}, 16'(bus.ce), 16'h0000);
        check({name, " addr"}, 16'(bus.address), 16'(pc));
    endtask

    alu_vec_t vecs [13];

    initial begin
        vecs[0]  = '{4'h4, 16'hF0F0, 16'h0FF0, 16'hFF00};
        vecs[1]  = '{4'h5, 16'hF0F0, 16'h0FF0, 16'h00F0};
        vecs[2]  = '{4'h6, 16'h1234, 16'h1111, 16'h2345};
        vecs[3]  = '{4'h6, 16'hFFFF, 16'h0001, 16'h0000};
        vecs[4]  = '{4'h7, 16'h0003, 16'h0005, 16'h0001};
        vecs[5]  = '{4'h7, 16'h0005, 16'h0005, 16'h0000};
        vecs[6]  = '{4'h7, 16'h0007, 16'h0003, 16'h0000};
        vecs[7]  = '{4'h7, 16'h0000, 16'hFFFF, 16'h0001};
        vecs[8]  = '{4'h8, 16'hFFFF, 16'h1234, 16'h0000};
        vecs[9]  = '{4'h8, 16'h0041, 16'h0000, 16'h0042};
        vecs[10] = '{4'h9, 16'h0000, 16'h0000, 16'hFFFF};
        vecs[11] = '{4'h9, 16'h0010, 16'h0000, 16'h000F};
        vecs[12] = '{4'hA, 16'h1111, 16'h2222, 16'h0000};

        // ALU table: R1,R2 <- operands, R3 <- R1 op R2, store R3, halt.
        for (int i = 0; i < 13; i++) begin
            fill_mem(16'hF000);
            mem[0]    = 16'h0801;
            mem[1]    = 16'h0812;
            mem[2]    = {vecs[i].op, 12'h312};
            mem[3]    = 16'h1903;
            mem[4]    = 16'hF000;
            mem[8'h80] = vecs[i].a;
            mem[8'h81] = vecs[i].b;
            do_reset();
            exp_q.push_back('{8'h90, vecs[i].want});
            release_reset();
            run_until_drained(30, $sformatf("alu vec %0d drained", i));
            check_halted(8'h05, $sformatf("alu vec %0d halt", i));
        end

        // Sum loop, then INC/DEC block with results stored to 0x30..0x33.
        fill_mem(16'hF000);
        mem[0] = 16'h4000; mem[1] = 16'h4111; mem[2] = 16'h0093; mem[3] = 16'h6110;
        mem[4] = 16'h8000; mem[5] = 16'h7203; mem[6] = 16'h3032; mem[7] = 16'h10A1;
        mem[8] = 16'h2140; mem[9] = 16'h000A; mem[10] = 16'h0000;
        mem[20] = 16'h8000; mem[21] = 16'h8110; mem[22] = 16'h9220; mem[23] = 16'h9330;
        mem[24] = 16'h1300; mem[25] = 16'h1311; mem[26] = 16'h1322; mem[27] = 16'h1333;
        mem[28] = 16'hF000;
        do_reset();
        exp_q.push_back('{8'h0A, 16'h002D});
        exp_q.push_back('{8'h30, 16'h000B});
        exp_q.push_back('{8'h31, 16'h002E});
        exp_q.push_back('{8'h32, 16'hFFFF});
        exp_q.push_back('{8'h33, 16'h0009});
        release_reset();
        run_until_drained(300, "sum loop drained");
        check("sum mem[10]", mem[10], 16'h002D);
        check_halted(8'd29, "sum loop halt");

        // END at address 5: bus stays idle, later WRITE never happens.
        fill_mem(16'hA000);
        mem[5] = 16'hF000; mem[6] = 16'h1400; mem[8'h40] = 16'h5555;
        do_reset();
        release_reset();
        repeat (30) @(negedge ck);
        check("end ce", 16'(bus.ce), 16'h0000);
        check("end we", 16'(bus.we), 16'h0000);
        check("end addr", 16'(bus.address), 16'h0006);
        check("end mem untouched", mem[8'h40], 16'h5555);
        do_reset();
        release_reset();
        @(negedge ck);
        check("restart exec addr", 16'(bus.address), 16'h0001);
        check("restart exec ce", 16'(bus.ce), 16'h0000);

        // PC wrap: JMP 255 holding a NOP, then fetch from 0.
        fill_mem(16'hA000);
        mem[0] = 16'h2FF0;
        do_reset();
        release_reset();
        repeat (2) @(negedge ck);
        check("jmp target addr", 16'(bus.address), 16'h00FF);
        check("jmp target ce", 16'(bus.ce), 16'h0001);
        @(negedge ck);
        check("wrapped pc", 16'(bus.address), 16'h0000);
        @(negedge ck);
        check("wrap fetch addr", 16'(bus.address), 16'h0000);
        check("wrap fetch ce", 16'(bus.ce), 16'h0001);

        // Reset during a WRITE's EXEC suppresses the strobe and the store.
        fill_mem(16'hA000);
        mem[0] = 16'h1500; mem[8'h50] = 16'h1234;
        do_reset();
        release_reset();
        @(posedge ck);
        #1 rst = 1'b0;
        #1;
        check("abort we", 16'(bus.we), 16'h0000);
        check("abort ce", 16'(bus.ce), 16'h0000);
        @(posedge ck);
        @(negedge ck);
        check("abort mem", mem[8'h50], 16'h1234);

        // Write lands before the fetch of the same word: fetched END halts.
        fill_mem(16'hA000);
        mem[0] = 16'h0101; mem[1] = 16'h1021; mem[2] = 16'hA000;
        mem[3] = 16'h1400; mem[8'h10] = 16'hF000;
        do_reset();
        exp_q.push_back('{8'h02, 16'hF000});
        release_reset();
        run_until_drained(20, "self-modify drained");
        check_halted(8'h03, "self-modify halt");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
